// File: rtl/ternary_pkg.sv
// ternary_pkg: balanced-ternary trit encoding and single-trit arithmetic helpers shared by tritone datapaths.
package ternary_pkg;
  typedef logic [1:0] trit_t;
  localparam trit_t T_ZERO = 2'b00;
  localparam trit_t T_POS_ONE = 2'b01;
  localparam trit_t T_NEG_ONE = 2'b10;
  localparam trit_t T_INVALID = 2'b11;
  typedef struct packed {
    trit_t sum;
    trit_t cout;
  } tadd_t;
  function automatic int t_int(trit_t t);
    return t == T_POS_ONE ? 1 : t == T_NEG_ONE ? -1 : 0;
  endfunction
  function automatic trit_t t_of(int v);
    return v > 0 ? T_POS_ONE : v < 0 ? T_NEG_ONE : T_ZERO;
  endfunction
  function automatic trit_t t_neg(trit_t t);
    return t == T_POS_ONE ? T_NEG_ONE : t == T_NEG_ONE ? T_POS_ONE : t;
  endfunction
  // T_INVALID inputs contribute zero, so sums never carry an invalid trit.
  function automatic tadd_t t_full_add(trit_t a, trit_t b, trit_t cin);
    tadd_t r;
    int s;
    s = t_int(a) + t_int(b) + t_int(cin);
    r.cout = t_of(s > 1 ? 1 : s < -1 ? -1 : 0);
    r.sum = t_of(s - 3 * t_int(r.cout));
    return r;
  endfunction
endpackage

// File: rtl/ternary_adder_rca.sv
// ternary_adder_rca: N-trit balanced-ternary ripple-carry adder.
module ternary_adder_rca
  import ternary_pkg::*;
#(
  parameter int N = 4
) (
  input  trit_t [N-1:0] x,
  input  trit_t [N-1:0] y,
  input  trit_t         cin,
  output trit_t [N-1:0] s,
  output trit_t         cout
);
  trit_t [N:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < N; i++) begin : g_bit
    tadd_t r;
    assign r = t_full_add(x[i], y[i], c[i]);
    assign s[i] = r.sum;
    assign c[i+1] = r.cout;
  end
  assign cout = c[N];
endmodule

// File: rtl/ternary_mac_seq.sv
// ternary_mac_seq: sequential balanced-ternary multiply/accumulate, one multiplier trit per cycle.
module ternary_mac_seq
  import ternary_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int ACC_WIDTH = 2 * WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  trit_t [WIDTH-1:0]       a,
  input  trit_t [WIDTH-1:0]       b,
  input  logic                    acc_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output trit_t [ACC_WIDTH-1:0]   result,
  output logic                    ovf,
  output logic                    err,
  output logic                    zero_flag,
  output logic                    neg_flag
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  trit_t [WIDTH-1:0] a_q, a_d, b_q, b_d, lo_q, lo_d;
  trit_t [WIDTH:0] hi_q, hi_d, pp, sum;
  trit_t [ACC_WIDTH-1:0] acc_q, acc_d, res_q, res_d, prod, asum;
  logic acc_en_q, acc_en_d, bad_q, bad_d, ovf_q, ovf_d, err_q, err_d;
  logic zero_q, zero_d, neg_q, neg_d, in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  trit_t c1, c2;
  logic unused_ok;
  function automatic logic has_inv(trit_t [WIDTH-1:0] v);
    logic r = 1'b0;
    for (int i = 0; i < WIDTH; i++) r |= v[i] == T_INVALID;
    return r;
  endfunction
  function automatic logic neg_of(trit_t [ACC_WIDTH-1:0] v);
    logic n = 1'b0;
    for (int i = 0; i < ACC_WIDTH; i++) if (v[i] != T_ZERO) n = v[i] == T_NEG_ONE;
    return n;
  endfunction
  always_comb begin
    for (int i = 0; i < WIDTH; i++)
      pp[i] = b_q[0] == T_POS_ONE ? a_q[i] : b_q[0] == T_NEG_ONE ? t_neg(a_q[i]) : T_ZERO;
    pp[WIDTH] = T_ZERO;
  end
  // hi holds the running sum shifted right by the step count; settled low trits collect in lo.
  ternary_adder_rca #(.N(WIDTH + 1)) u_pp (.x(hi_q), .y(pp), .cin(T_ZERO), .s(sum), .cout(c1));
  assign prod = {sum, lo_q[WIDTH-1:1]};
  ternary_adder_rca #(.N(ACC_WIDTH)) u_acc (.x(acc_q), .y(prod), .cin(T_ZERO), .s(asum), .cout(c2));
  assign unused_ok = ^c1;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    hi_d = hi_q;
    lo_d = lo_q;
    acc_d = acc_q;
    res_d = res_q;
    acc_en_d = acc_en_q;
    bad_d = bad_q;
    ovf_d = ovf_q;
    err_d = err_q;
    zero_d = zero_q;
    neg_d = neg_q;
    in_ready_d = in_ready_q;
    out_valid_d = out_valid_q;
    if (state_q == IDLE && in_valid) begin
      state_d = CALC;
      cnt_d = '0;
      a_d = a;
      b_d = b;
      hi_d = '0;
      lo_d = '0;
      acc_en_d = acc_en;
      bad_d = has_inv(a) | has_inv(b);
      res_d = '0;
      ovf_d = 1'b0;
      err_d = 1'b0;
      zero_d = 1'b1;
      neg_d = 1'b0;
      in_ready_d = 1'b0;
    end else if (state_q == CALC) begin
      hi_d = {T_ZERO, sum[WIDTH:1]};
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
      b_d = {T_ZERO, b_q[WIDTH-1:1]};
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = DONE;
        out_valid_d = 1'b1;
        res_d = bad_q ? '0 : acc_en_q ? asum : prod;
        ovf_d = !bad_q && acc_en_q && c2 != T_ZERO;
        err_d = bad_q;
        acc_d = bad_q ? acc_q : res_d;
        zero_d = res_d == '0;
        neg_d = neg_of(res_d);
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
      out_valid_d = 1'b0;
      in_ready_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      acc_q <= '0;
      res_q <= '0;
      acc_en_q <= 1'b0;
      bad_q <= 1'b0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
      zero_q <= 1'b1;
      neg_q <= 1'b0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      acc_q <= acc_d;
      res_q <= res_d;
      acc_en_q <= acc_en_d;
      bad_q <= bad_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
      zero_q <= zero_d;
      neg_q <= neg_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign result = res_q;
  assign ovf = ovf_q;
  assign err = err_q;
  assign zero_flag = zero_q;
  assign neg_flag = neg_q;
endmodule
